// File: rtl/sk9822_pkg.sv
// Shared constants, FSM state type and helpers for the SK9822 frame controller.
package sk9822_pkg;

    localparam logic [31:0] START_WORD = 32'h0000_0000;
    localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
    localparam logic [2:0]  LED_HDR    = 3'b111;
    localparam int          PIX_W      = 29;

    typedef enum logic [1:0] {
        IDLE,
        START,
        LED,
        END
    } state_e;

    // Trailing all-ones words needed to push clock edges through the whole chain.
    function automatic int end_words(input int led_num);
        int n;
        n = (led_num + 63) / 64;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/sk9822_shift.sv
// 32-bit load/ready word serializer for the SK9822 two-wire interface.
// SCK half period is CLK_DIV clk cycles; data changes only while SCK is low.
// ready rises in the last cycle of the final bit's high phase so a word
// loaded then continues SCK without a gap.
module sk9822_shift #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    output logic        ready,
    output logic        ck,
    output logic        da,
    output logic        done
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [31:0]      sr_q, sr_d;
    logic [4:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ck_q, ck_d;
    logic             da_q, da_d;
    logic             act_q, act_d;
    logic             done_q, done_d;
    logic             div_end;
    logic             last_bit;

    assign div_end  = (div_q == DIV_LAST);
    assign last_bit = act_q && ck_q && div_end && (bit_q == 5'd31);
    assign ready    = !act_q || last_bit;
    assign ck       = ck_q;
    assign da       = da_q;
    assign done     = done_q;

    // Half-period timing, bit stepping on SCK falling edges, and word loading.
    always_comb begin
        sr_d   = sr_q;
        bit_d  = bit_q;
        div_d  = div_q;
        ck_d   = ck_q;
        da_d   = da_q;
        act_d  = act_q;
        done_d = 1'b0;
        if (act_q) begin
            if (div_end) begin
                div_d = '0;
                ck_d  = !ck_q;
                if (ck_q) begin
                    if (bit_q != 5'd31) begin
                        da_d  = sr_q[31];
                        sr_d  = {sr_q[30:0], 1'b0};
                        bit_d = bit_q + 5'd1;
                    end else if (!load) begin
                        // Final falling edge with nothing queued: park SCK low, hold data.
                        act_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        if (load && ready) begin
            sr_d  = {word[30:0], 1'b0};
            da_d  = word[31];
            bit_d = '0;
            div_d = '0;
            ck_d  = 1'b0;
            act_d = 1'b1;
        end
    end

    // Serializer state register; reset drives the LED lines low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            bit_q  <= '0;
            div_q  <= '0;
            ck_q   <= 1'b0;
            da_q   <= 1'b0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            bit_q  <= bit_d;
            div_q  <= div_d;
            ck_q   <= ck_d;
            da_q   <= da_d;
            act_q  <= act_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/sk9822_frame_ctrl.sv
// SK9822 LED string frame scheduler: pixel buffer, refresh timer, frame FSM
// and word serializer. Optional macro SK9822_DOUBLE_BUF_EN selects a
// double-banked pixel store that swaps at frame launch; the default build
// reads a single live bank.
module sk9822_frame_ctrl
    import sk9822_pkg::*;
#(
    parameter int LED_NUM     = 12,
    parameter int ADDR_W      = 4,
    parameter int CLK_DIV     = 25,
    parameter int REFRESH_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [28:0]       wr_data,
    input  logic              refresh_req,
    output logic              busy,
    output logic              frame_done,
    output logic              sk9822_ck,
    output logic              sk9822_da
);

    localparam int END_WORDS = end_words(LED_NUM);
    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int CNT_W     = (ADDR_W > 9) ? ADDR_W : 9;
    localparam int TMR_W     = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    localparam logic [CNT_W-1:0]  LED_LAST  = CNT_W'(LED_NUM - 1);
    localparam logic [CNT_W-1:0]  END_CNT   = CNT_W'(END_WORDS);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REFRESH_CYC - 1);
    localparam logic [ADDR_W:0]   LED_LIMIT = (ADDR_W + 1)'(LED_NUM);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              pending_q, pending_d;
    logic              busy_q, busy_d;
    logic              launch;
    logic              tmr_hit;
    logic              wr_ok;
    logic              sh_load;
    logic              sh_ready;
    logic              sh_done;
    logic [31:0]       sh_word;
    logic [PIX_W-1:0]  rd_pix;
    logic [ADDR_W-1:0] rd_addr;

    assign rd_addr    = cnt_q[ADDR_W-1:0];
    assign wr_ok      = wr_en && ({1'b0, wr_addr} < LED_LIMIT);
    assign tmr_hit    = (tmr_q == TMR_LAST);
    assign busy       = busy_q;
    assign frame_done = sh_done;

`ifdef SK9822_DOUBLE_BUF_EN
    logic [PIX_W-1:0]  bank_q [2][DEPTH];
    logic [PIX_W-1:0]  bank_d [2][DEPTH];
    logic              front_q, front_d;
    logic [DEPTH-1:0]  dirty_q, dirty_d;
    logic [ADDR_W-1:0] cp_idx_q, cp_idx_d;
    logic              cp_act_q, cp_act_d;
    logic              back_sel;

    assign back_sel = !front_q;
    assign rd_pix   = bank_q[front_q][rd_addr];

    // Back-bank writes, bank swap at launch, and background front-to-back copy.
    // Entries written since the swap are marked dirty so the copy never clobbers them.
    always_comb begin
        bank_d   = bank_q;
        front_d  = front_q;
        dirty_d  = dirty_q;
        cp_idx_d = cp_idx_q;
        cp_act_d = cp_act_q;
        if (cp_act_q) begin
            if (!dirty_q[cp_idx_q]) begin
                bank_d[back_sel][cp_idx_q] = bank_q[front_q][cp_idx_q];
            end
            if (cp_idx_q == ADDR_W'(LED_NUM - 1)) begin
                cp_act_d = 1'b0;
            end else begin
                cp_idx_d = cp_idx_q + 1'b1;
            end
        end
        if (wr_ok) begin
            bank_d[back_sel][wr_addr] = wr_data;
            dirty_d[wr_addr]          = 1'b1;
        end
        if (launch) begin
            front_d  = back_sel;
            dirty_d  = '0;
            cp_idx_d = '0;
            cp_act_d = 1'b1;
        end
    end

    // Pixel bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
            front_q  <= 1'b0;
            dirty_q  <= '0;
            cp_idx_q <= '0;
            cp_act_q <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            front_q  <= front_d;
            dirty_q  <= dirty_d;
            cp_idx_q <= cp_idx_d;
            cp_act_q <= cp_act_d;
        end
    end
`else
    logic [PIX_W-1:0] pix_q [DEPTH];
    logic [PIX_W-1:0] pix_d [DEPTH];

    // Live read: the serializer sees whatever is stored when the LED word is loaded.
    assign rd_pix = pix_q[rd_addr];

    // Host pixel writes; out-of-range addresses are dropped.
    always_comb begin
        pix_d = pix_q;
        if (wr_ok) begin
            pix_d[wr_addr] = wr_data;
        end
    end

    // Pixel buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pix_q[i] <= '0;
            end
        end else begin
            pix_q <= pix_d;
        end
    end
`endif

    // Frame sequencing: launch on pending, issue start/LED/end words back to back,
    // return to IDLE once the last end-word bit has been clocked out.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        launch    = 1'b0;
        sh_load   = 1'b0;
        sh_word   = START_WORD;
        tmr_d     = tmr_hit ? '0 : tmr_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    launch  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                sh_load = 1'b1;
                sh_word = START_WORD;
                if (sh_ready) begin
                    cnt_d   = '0;
                    state_d = LED;
                end
            end
            LED: begin
                sh_load = 1'b1;
                sh_word = {LED_HDR, rd_pix};
                if (sh_ready) begin
                    if (cnt_q == LED_LAST) begin
                        cnt_d   = '0;
                        state_d = END;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            END: begin
                sh_load = (cnt_q != END_CNT);
                sh_word = END_WORD;
                if (sh_ready) begin
                    if (cnt_q != END_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        // Final bit is in its last high cycle: busy drops with frame_done.
                        busy_d = 1'b0;
                    end
                end
                if (sh_done) begin
                    state_d = IDLE;
                end
            end
        endcase
        pending_d = (pending_q && !launch) || refresh_req || tmr_hit;
    end

    // Control registers for the frame FSM, refresh timer and request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

    sk9822_shift #(
        .CLK_DIV(CLK_DIV)
    ) u_shift (
        .clk  (clk),
        .rst_n(rst_n),
        .load (sh_load),
        .word (sh_word),
        .ready(sh_ready),
        .ck   (sk9822_ck),
        .da   (sk9822_da),
        .done (sh_done)
    );

endmodule

// File: tb/tb_sk9822_frame_ctrl.sv
// Bench for sk9822_frame_ctrl: a 2-LED instance with a 2000-cycle refresh timer
// and a 12-LED instance with a timer too long to fire. Expected words are queued
// per instance; a monitor deserialises each instance's SCK/DA stream and pops.
`timescale 1ns/1ps
module tb_sk9822_frame_ctrl;

    localparam int LEN_A = 513;
    localparam int LEN_B = 1793;

    logic        clk = 1'b0;
    logic [1:0]  rstn_w = 2'b11;
    logic        a_wr_en = 1'b0, a_req = 1'b0;
    logic [0:0]  a_wr_addr = '0;
    logic [28:0] a_wr_data = '0;
    logic        b_wr_en = 1'b0, b_req = 1'b0;
    logic [3:0]  b_wr_addr = '0;
    logic [28:0] b_wr_data = '0;
    logic [1:0]  busy_w, done_w, ck_w, da_w;

    always #5 clk = ~clk;

    sk9822_frame_ctrl #(
        .LED_NUM(2), .ADDR_W(1), .CLK_DIV(2), .REFRESH_CYC(2000)
    ) u_dut_a (
        .clk(clk), .rst_n(rstn_w[0]), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .refresh_req(a_req), .busy(busy_w[0]),
        .frame_done(done_w[0]), .sk9822_ck(ck_w[0]), .sk9822_da(da_w[0])
    );

    sk9822_frame_ctrl #(
        .LED_NUM(12), .ADDR_W(4), .CLK_DIV(2), .REFRESH_CYC(1_000_000)
    ) u_dut_b (
        .clk(clk), .rst_n(rstn_w[1]), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .refresh_req(b_req), .busy(busy_w[1]),
        .frame_done(done_w[1]), .sk9822_ck(ck_w[1]), .sk9822_da(da_w[1])
    );

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] b_led [12];
    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    int          bits      [2] = '{0, 0};
    logic [31:0] shreg     [2] = '{32'h0, 32'h0};
    logic        ck_prev   [2] = '{1'b0, 1'b0};
    logic        busy_prev [2] = '{1'b0, 1'b0};
    logic        done_prev [2] = '{1'b0, 1'b0};
    int          busy_cnt  [2] = '{0, 0};
    int          nrise     [2] = '{0, 0};
    int          nframes   [2] = '{0, 0};
    int          last_rise [2] = '{0, 0};
    int          prev_rise [2] = '{0, 0};
    int          last_done [2] = '{0, 0};
    int          gap       [2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic check_word(input int d, input logic [31:0] got);
        logic [31:0] want;
        bit          have;
        have = 1'b0;
        want = '0;
        vectors++;
        if (d == 0 && exp_a.size() > 0) begin
            want = exp_a.pop_front();
            have = 1'b1;
        end else if (d == 1 && exp_b.size() > 0) begin
            want = exp_b.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            fails++;
            $display("FAIL word dut%0d: got %08h, required no word (nothing expected)", d, got);
        end else if (got !== want) begin
            fails++;
            $display("FAIL word dut%0d: got %08h, required %08h", d, got, want);
        end
    endtask

    // Monitor: deserialise on SCK rising edges, track busy length and launches.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn_w[d]) begin
                bits[d]      = 0;
                ck_prev[d]   = 1'b0;
                busy_prev[d] = 1'b0;
                done_prev[d] = 1'b0;
                busy_cnt[d]  = 0;
            end else begin
                if (ck_w[d] && !ck_prev[d]) begin
                    shreg[d] = {shreg[d][30:0], da_w[d]};
                    bits[d]  = bits[d] + 1;
                    if (bits[d] == 32) begin
                        bits[d] = 0;
                        check_word(d, shreg[d]);
                    end
                end
                if (busy_w[d]) busy_cnt[d] = busy_cnt[d] + 1;
                if (busy_w[d] && !busy_prev[d]) begin
                    prev_rise[d] = last_rise[d];
                    last_rise[d] = cyc;
                    if (nframes[d] > 0) gap[d] = cyc - last_done[d];
                    nrise[d] = nrise[d] + 1;
                end
                if (done_w[d]) begin
                    vectors++;
                    if (done_prev[d] || busy_w[d] || busy_cnt[d] != ((d == 0) ? LEN_A : LEN_B)) begin
                        fails++;
                        $display("FAIL frame_len dut%0d: busy %0d cycles, busy_at_done %0b, repeat_pulse %0b; required %0d cycles, 0, 0",
                                 d, busy_cnt[d], busy_w[d], done_prev[d], (d == 0) ? LEN_A : LEN_B);
                    end
                    busy_cnt[d]  = 0;
                    last_done[d] = cyc;
                    nframes[d]   = nframes[d] + 1;
                end
                ck_prev[d]   = ck_w[d];
                busy_prev[d] = busy_w[d];
                done_prev[d] = done_w[d];
            end
        end
    end

    task automatic wait_for(input int d, input bit frames, input int target, input int budget, input string what);
        int n;
        n = 0;
        while (((frames ? nframes[d] : nrise[d]) < target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if ((frames ? nframes[d] : nrise[d]) < target) begin
            fails++;
            $display("FAIL %s: count %0d after %0d cycles, required %0d",
                     what, frames ? nframes[d] : nrise[d], n, target);
        end
    endtask

    task automatic pulse_req(input int d);
        @(negedge clk);
        if (d == 0) a_req = 1'b1; else b_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic wr(input int d, input int addr, input logic [28:0] data);
        @(negedge clk);
        if (d == 0) begin
            a_wr_en = 1'b1; a_wr_addr = 1'(addr); a_wr_data = data;
        end else begin
            b_wr_en = 1'b1; b_wr_addr = 4'(addr); b_wr_data = data;
        end
        @(negedge clk);
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic push_a(input logic [31:0] l0, input logic [31:0] l1);
        exp_a.push_back(32'h0000_0000);
        exp_a.push_back(l0);
        exp_a.push_back(l1);
        exp_a.push_back(32'hFFFF_FFFF);
    endtask

    task automatic push_b();
        exp_b.push_back(32'h0000_0000);
        for (int i = 0; i < 12; i++) exp_b.push_back(b_led[i]);
        exp_b.push_back(32'hFFFF_FFFF);
    endtask

    task automatic clear_b_led();
        for (int i = 0; i < 12; i++) b_led[i] = 32'hE000_0000;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rstn_w = 2'b00;
        repeat (5) @(negedge clk);
        chk("reset_a", {28'h0, ck_w[0], da_w[0], busy_w[0], done_w[0]}, 32'h0);
        chk("reset_b", {28'h0, ck_w[1], da_w[1], busy_w[1], done_w[1]}, 32'h0);

        // Automatic frames with an empty buffer, 2000 cycles apart.
        push_a(32'hE000_0000, 32'hE000_0000);
        push_a(32'hE000_0000, 32'hE000_0000);
        rstn_w[0] = 1'b1;
        wait_for(0, 1'b0, 2, 4500, "auto_launch");
        chk("auto_period", 32'(last_rise[0] - prev_rise[0]), 32'd2000);
        wait_for(0, 1'b1, 2, 700, "auto_done");

        // Written pixels, frame on request.
        push_a(32'hFF00_00FF, 32'hE100_FF00);
        wr(0, 0, 29'h1F_0000FF);
        wr(0, 1, 29'h01_00FF00);
        pulse_req(0);
        wait_for(0, 1'b1, 3, 700, "req_frame");
        chk("queue_a_empty", 32'(exp_a.size()), 32'd0);
        rstn_w[0] = 1'b0;

        // Coalescing: three requests during a frame yield one follow-on frame.
        rstn_w[1] = 1'b1;
        repeat (3) @(negedge clk);
        clear_b_led();
        push_b();
        push_b();
        pulse_req(1);
        wait_for(1, 1'b0, 1, 20, "req_launch");
        for (int k = 0; k < 3; k++) begin
            repeat (50) @(negedge clk);
            pulse_req(1);
        end
        wait_for(1, 1'b1, 2, 4000, "coalesce_frames");
        chk("relaunch_gap", 32'(gap[1]), 32'd2);
        repeat (3000) @(negedge clk);
        chk("no_third_launch", 32'(nrise[1]), 32'd2);
        chk("no_third_frame", 32'(nframes[1]), 32'd2);

        // Writes while LED word 2 is shifting.
        wr(1, 1, 29'h05_123456);
        wr(1, 5, 29'h0A_ABCDEF);
        clear_b_led();
        b_led[1] = 32'hE512_3456;
`ifdef SK9822_DOUBLE_BUF_EN
        b_led[5] = 32'hEAAB_CDEF;
`else
        b_led[5] = 32'hFF00_0001;
`endif
        push_b();
        b_led[1] = 32'hF077_7777;
        b_led[5] = 32'hFF00_0001;
        push_b();
        pulse_req(1);
        wait_for(1, 1'b0, 3, 20, "mid_launch");
        repeat (440) @(negedge clk);
        wr(1, 5, 29'h1F_000001);
        wr(1, 1, 29'h10_777777);
        wr(1, 12, 29'h1F_FFFFFF);
        pulse_req(1);
        wait_for(1, 1'b1, 4, 4000, "mid_frames");
        chk("queue_b_mid", 32'(exp_b.size()), 32'd0);

        // Asynchronous reset in the middle of an LED word.
        exp_b.push_back(32'h0000_0000);
        exp_b.push_back(32'hE000_0000);
        exp_b.push_back(32'hF077_7777);
        pulse_req(1);
        wait_for(1, 1'b0, 5, 20, "abort_launch");
        repeat (440) @(negedge clk);
        n = 0;
        while (!ck_w[1] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ck_high_before_reset", {31'h0, ck_w[1]}, 32'd1);
        #2 rstn_w[1] = 1'b0;
        #1;
        chk("reset_ck_da_busy", {29'h0, ck_w[1], da_w[1], busy_w[1]}, 32'h0);
        chk("abort_queue", 32'(exp_b.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn_w[1] = 1'b1;
        repeat (3) @(negedge clk);
        clear_b_led();
        push_b();
        pulse_req(1);
        wait_for(1, 1'b1, 5, 2000, "post_reset_frame");
        chk("queue_b_end", 32'(exp_b.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/sk9822_frame_ctrl.md
Name: sk9822_frame_ctrl

Overview:
Frame scheduler for a daisy-chained SK9822 LED string. Holds a per-LED pixel buffer written by the host logic. Launches a complete refresh frame (start word, one word per LED, end word(s)) periodically or on request. Drives the two-wire clock/data lines through a word serializer with continuous SCK across word boundaries.

Parameters:
LED_NUM, 12, number of chained LEDs (1..256)
ADDR_W, 4, pixel address width, must satisfy 2**ADDR_W >= LED_NUM
CLK_DIV, 25, clk cycles per SCK half period (>=1); bit period = 2*CLK_DIV
REFRESH_CYC, 1_000_000, clk cycles between automatic frames (>= frame length)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  pixel write strobe
wr_addr  in  ADDR_W  LED index, 0 = first LED in chain
wr_data  in  29  {bright[4:0], B[7:0], G[7:0], R[7:0]}
refresh_req  in  1  one-cycle pulse: request a frame now
busy  out  1  high from frame launch until last end-word bit completes
frame_done  out  1  one-cycle pulse when a frame completes
sk9822_ck  out  1  LED clock, idle low
sk9822_da  out  1  LED data, sampled by LEDs on SCK rising edge

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: sk9822_ck=0, sk9822_da=0, busy=0, frame_done=0, state IDLE, refresh timer 0, pending=0, all pixel entries 0 (brightness 0 = off).
- Pixel write: the entry updates on the clk edge with wr_en=1. wr_addr >= LED_NUM is ignored.
- Pixel reads: an entry is read in the cycle its word is loaded into the serializer. A write during a frame is visible if it lands before that entry's load cycle. Same-cycle write and load sends the old value.
- LED word format: {3'b111, bright, B, G, R}, MSB first.
- Start word is 32'h0000_0000.
- End words are END_WORDS = max(1, ceil(LED_NUM/64)) words of 32'hFFFF_FFFF.
- Refresh timer: free-running 0..REFRESH_CYC-1. Reaching REFRESH_CYC-1 sets pending.
- refresh_req=1 also sets pending.
- Requests coalesce: pending is a single bit.
- pending is cleared in the cycle a frame launches. A request arriving in that same cycle sets pending again.
- FSM states: IDLE -> START (when pending) -> LED (word index 0..LED_NUM-1) -> END (END_WORDS words) -> IDLE.
- Each state issues its word via load/ready to the serializer. The next word is loaded in the same cycle ready rises, so there is no SCK gap between words.
- busy rises in the cycle after launch and falls with frame_done.
- frame_done pulses for one cycle when the serializer reports the final bit's SCK falling edge.
- If pending is set while busy, the next frame launches on the first IDLE cycle, i.e. one cycle after frame_done.
- Serializer timing: word accepted at cycle t; da shows bit31 from t+1; ck rises at t+1+CLK_DIV; ck falls at t+1+2*CLK_DIV, with the next bit presented on da in the same cycle.
- Data changes only while ck is low. After the last word, ck stays low and da holds its last value.
- Frame length: 32*(1+LED_NUM+END_WORDS)*2*CLK_DIV cycles, plus 1 launch cycle.
- Reset asserted mid-frame forces ck/da low immediately (asynchronous). After release the block restarts from IDLE. LEDs resynchronise on the next start word.

Optional Feature:
SK9822_DOUBLE_BUF_EN
- Defined: two pixel banks. Writes go to the back bank. Banks swap in the launch cycle, so a frame shows a consistent snapshot. After the swap, the new back bank is copied from the front bank, one entry per cycle; a write to an entry wins over its copy.
- Undefined: a single bank with the live-read behaviour above.

Decomposition:
- Package sk9822_pkg: START_WORD, END_WORD, the LED word header 3'b111, an FSM state enum {IDLE, START, LED, END}, and an END_WORDS helper function.
- Sub-module sk9822_shift: 32-bit load/ready serializer with CLK_DIV half-period counter and bit counter. Outputs ck, da, ready, and a last-bit-done pulse.

Test Plan:
1. Reset, LED_NUM=2, CLK_DIV=2, write addr0=29'h1F_0000FF and addr1=29'h01_00FF00, then pulse refresh_req -> the bench shift-captures on ck rising edges: 00000000, FF0000FF, E100FF00, FFFFFFFF. busy lasts 512+1 cycles, then a single frame_done.
2. No writes, REFRESH_CYC=2000 -> frames auto-launch every 2000 cycles. Each LED word is E0000000.
3. refresh_req pulsed three times during a busy frame -> exactly one extra frame starts one cycle after frame_done.
4. Write to addr 5 while LED word 2 shifts (LED_NUM=12) -> the new value appears in the current frame. A write to addr 1 at the same time appears only in the next frame. A write to addr 12 is ignored.
5. rst_n low mid-LED-word -> ck=da=0 within the same cycle. After release, the next frame is complete and correct.
6. SK9822_DOUBLE_BUF_EN defined: write addr 5 mid-frame -> the current frame shows the old value and the next frame shows the new value.
